// File: rtl/ppm_decoder.sv
// 4-PPM receive decoder: synchronizes the active-low Din line, locks to the SOF
// pulse pair, decodes four symbols into a byte and validates the EOF pulse.
module ppm_decoder #(
  parameter int SLOT_CYCLES  = 128,
  parameter int PULSE_CYCLES = 16,
  parameter int TOL          = 4,
  parameter int EOF_CYCLES   = 64,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_HOLD    = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Din,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W     = 10;
  localparam int HOLD_W    = $clog2(IDLE_HOLD + 1);
  localparam int QTR       = SLOT_CYCLES / 4;
  localparam int SOF_RISE  = PULSE_CYCLES;
  localparam int SOF2_FALL = SLOT_CYCLES / 2 + PULSE_CYCLES;
  localparam int SOF2_RISE = SOF2_FALL + PULSE_CYCLES;
  localparam int DATA_END  = 5 * SLOT_CYCLES - 1;
  localparam int EOF_FALL  = 5 * SLOT_CYCLES + EOF_CYCLES / 2;
  localparam int EOF_HIGH  = EOF_FALL + PULSE_CYCLES + TOL;
  localparam int EOF_END   = 5 * SLOT_CYCLES + EOF_CYCLES - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SOF1, S_GAP, S_SOF2, S_TAIL, S_DATA, S_EOF, S_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lvl_q, lvl_d, fall_q, fall_d, rise_q, rise_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   got_q, got_d;
  logic [7:0]             byte_q, byte_d, data_q, data_d;
  logic                   dv_q, dv_d, fe_q, fe_d, busy_q, busy_d;
  logic                   err;
  int                     c, off, sub;
  logic [1:0]             sym, slot;

  function automatic logic near(input int v, input int ctr);
    return (v >= ctr - TOL) && (v <= ctr + TOL);
  endfunction

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], Din};
    lvl_d  = sync_q[SYNC_STAGES-1];
    fall_d = lvl_q & ~sync_q[SYNC_STAGES-1];
    rise_d = ~lvl_q & sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    got_d   = got_q;
    byte_d  = byte_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    busy_d  = busy_q;
    err     = 1'b0;
    c       = int'(cnt_q);
    off     = c % SLOT_CYCLES;
    sub     = off % QTR;
    sym     = 2'(off / QTR);
    slot    = 2'(c / SLOT_CYCLES - 1);
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        got_d  = 1'b0;
        byte_d = '0;
        busy_d = 1'b0;
        // Look one stage ahead so cnt=0 and busy=1 line up with the detected edge;
        // the registered edge covers a fall that lands on the strobe cycle.
        if (fall_d) begin
          state_d = S_SOF1;
          busy_d  = 1'b1;
        end else if (fall_q) begin
          state_d = S_SOF1;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      S_SOF1: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rise_q) begin
          if (near(c, SOF_RISE)) state_d = S_GAP;
          else err = 1'b1;
        end else if (c >= SOF_RISE + TOL) err = 1'b1;
      end
      S_GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fall_q) begin
          if (near(c, SOF2_FALL)) state_d = S_SOF2;
          else err = 1'b1;
        end else if (c >= SOF2_FALL + TOL) err = 1'b1;
      end
      S_SOF2: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rise_q) begin
          if (near(c, SOF2_RISE)) state_d = S_TAIL;
          else err = 1'b1;
        end else if (c >= SOF2_RISE + TOL) err = 1'b1;
      end
      S_TAIL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fall_q) err = 1'b1;
        else if (c == SLOT_CYCLES - 1) begin
          state_d = S_DATA;
          got_d   = 1'b0;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fall_q) begin
          if (got_q || !near(sub, QTR / 2)) err = 1'b1;
          else begin
            got_d = 1'b1;
            byte_d[{slot, 1'b0} +: 2] = sym;
          end
        end
        // Slot close: a pulse is mandatory, and only symbol 3 may still be low.
        if (off == SLOT_CYCLES - 1) begin
          if (!got_q || (!lvl_q && byte_q[{slot, 1'b0} +: 2] != 2'd3)) err = 1'b1;
          got_d = 1'b0;
          if (c == DATA_END) state_d = S_EOF;
        end
      end
      S_EOF: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fall_q) begin
          if (got_q || !near(c, EOF_FALL)) err = 1'b1;
          else got_d = 1'b1;
        end else if (!got_q && c >= EOF_FALL + TOL) err = 1'b1;
        if (got_q && c == EOF_HIGH && !lvl_q) err = 1'b1;
        if (c == EOF_END) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          dv_d    = 1'b1;
          data_d  = byte_q;
        end
      end
      S_ERR: begin
        if (!lvl_q) hold_d = '0;
        else if (hold_q == HOLD_W'(IDLE_HOLD - 1)) begin
          hold_d  = '0;
          state_d = S_IDLE;
        end else hold_d = hold_q + HOLD_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // Errors outrank any advance or completion decided above.
    if (err) begin
      state_d = S_ERR;
      fe_d    = 1'b1;
      dv_d    = 1'b0;
      data_d  = data_q;
      busy_d  = 1'b0;
      hold_d  = '0;
      got_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync_q  <= '1;
      lvl_q   <= 1'b1;
      fall_q  <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      got_q   <= 1'b0;
      byte_q  <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      lvl_q   <= lvl_d;
      fall_q  <= fall_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      got_q   <= got_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign busy       = busy_q;

endmodule

// File: doc/ppm_decoder.md
Name: ppm_decoder

Overview:
- Receive-side counterpart of the PPM encoder in the VLC link.
- Samples the active-low optical Din line and locks to the SOF pulse pair.
- Decodes four 4-PPM symbols (2 bits each, LSB-pair first) into one byte and validates the EOF pulse.
- Presents the byte on a parallel port with a one-cycle valid strobe, feeding downstream byte sinks (UART/buffer).

Parameters:
- SLOT_CYCLES, 128, clocks per SOF/data symbol slot (power of two).
- PULSE_CYCLES, 16, nominal low-pulse width.
- TOL, 4, ± tolerance in clocks on every edge-position and width check (must be < 16).
- EOF_CYCLES, 64, EOF window length.
- SYNC_STAGES, 2, input synchronizer depth.
- IDLE_HOLD, 128, consecutive high samples required to re-arm after an error.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- Din  input  1  PPM line; idle high, pulse = low.
- data_out  output  8  last decoded byte.
- data_valid  output  1  one-cycle strobe; data_out is valid in this cycle.
- frame_err  output  1  one-cycle strobe on any framing violation.
- busy  output  1  high from SOF detect until frame end or error.

Behaviour:
- Reset: one clock domain, reset synchronous and active-high. All outputs 0, synchronizer flops 1, FSM in IDLE. Asserting rst mid-frame discards the partial byte with no strobe.
- Input path: SYNC_STAGES flops, then a registered edge detector. A falling edge is detected SYNC_STAGES+1 clocks after Din falls.
- E0 = cycle the SOF first falling edge is detected. A free counter cnt (10 bits) is 0 at E0 and increments every cycle while busy.
- IDLE: busy=0. A falling edge moves the FSM to SOF1; busy=1 and cnt=0 in that cycle.
- SOF1:
  - Rising edge at cnt in [16±TOL] → SOF_GAP.
  - Rising edge elsewhere, or no rise by cnt=16+TOL → ERR.
- SOF_GAP:
  - Falling edge at cnt in [80±TOL] → SOF2.
  - Any other fall, or none by 80+TOL → ERR.
- SOF2:
  - Rising edge at cnt in [96±TOL] → DATA, sym=0.
  - Otherwise → ERR.
  - The line must stay high until cnt=128.
- DATA:
  - Slot k (k=0..3) spans cnt = 128(k+1) .. 128(k+1)+127; offset = cnt mod 128.
  - Exactly one falling edge is required per slot, with offset[4:0] in [16±TOL]. Decoded symbol = offset[6:5] (16→0, 48→1, 80→2, 112→3). Symbol k is written to byte bits [2k+1:2k].
  - A second fall in the same slot, no fall in the slot, or an out-of-tolerance offset → ERR.
  - A low level crossing a slot boundary is legal only for symbol 3.
- EOF:
  - Window spans cnt 640..703.
  - Exactly one falling edge at cnt in [672±TOL] is required, and the line must be high again by cnt 688+TOL.
  - At cnt=704: data_out <= assembled byte, data_valid=1 for one cycle, busy=0, FSM → IDLE.
  - Violation → ERR.
- ERR:
  - frame_err=1 for exactly the cycle of entry; data_out unchanged; busy=0.
  - Stay in ERR until IDLE_HOLD consecutive high samples, then → IDLE. Any low sample restarts the hold count.
- Edge-detect priority: if two conditions are evaluated in the same cycle, an error outranks a state advance.
- A falling edge arriving in the same cycle as the data_valid strobe is handled in IDLE on the next cycle. Back-to-back frames with zero gap are therefore accepted.
- cnt never wraps within a frame; the maximum value is 704.

Test Plan:
- Byte 0xB4 (symbols 0,1,3,2): Din falls at t0; fall at t0+144/304/496/592, each low 16; EOF low at t0+672..687. Required: data_out=0xB4, data_valid=1 exactly at E0+704, frame_err never set.
- Bytes 0x00 then 0xFF back-to-back, no idle gap. Required: two data_valid strobes 704 clocks apart with 0x00 then 0xFF. For 0xFF, the low in every slot 112..127 is accepted.
- Jitter: every edge of a 0x5A frame shifted by +TOL, then by -TOL. Required: 0x5A decoded. Repeat with a shift of TOL+1. Required: frame_err pulse, no data_valid.
- SOF gap fall at cnt 70 → frame_err. Then a held-low line for 300 clocks → no re-arm. Then 128 high cycles followed by a valid 0x3C frame → data_valid with 0x3C.
- Missing pulse in slot 2 → frame_err at cnt 512. An extra fall in slot 1 → frame_err at that edge. Missing EOF → frame_err at cnt 672+TOL+1.
- rst asserted for one cycle at cnt 400 of a frame → outputs 0, busy=0, no strobe. The following valid 0xA5 frame decodes correctly.
